// File: rtl/leaf_syndrome_loader_if.sv
// Syndrome word stream into the leaf loader: data/valid/last with ready back-pressure.
interface leaf_syndrome_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/leaf_syndrome_loader.sv
// Assembles one round's syndrome bitmap from a word stream, pulses new_round_start and holds it until the leaf finishes.
// Optional watchdog enabled by defining LOADER_TIMEOUT_EN.
module leaf_syndrome_loader #(
  parameter int CODE_DISTANCE_X     = 3,
  parameter int CODE_DISTANCE_Z     = 2,
  parameter int WORD_WIDTH          = 8,
  parameter int ROUND_COUNTER_WIDTH = 16,
  parameter int TIMEOUT_CYCLES      = 4096,
  localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PU_COUNT           = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int WORD_COUNT         = (PU_COUNT + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int WORD_IDX_WIDTH     = $clog2(WORD_COUNT + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  leaf_syndrome_loader_if.slave          syn,
  output logic [PU_COUNT-1:0]            is_error_syndromes,
  output logic                           new_round_start,
  input  logic                           result_valid,
  input  logic                           deadlock,
  output logic                           busy,
  output logic                           round_done,
  output logic                           round_error,
  output logic [ROUND_COUNTER_WIDTH-1:0] round_count
);

  typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

  localparam logic [WORD_WIDTH-1:0] WORD_ONES = '1;

  state_t                    state;
  logic [WORD_IDX_WIDTH-1:0] idx;
  logic                      ready;
  logic                      accept;
  logic                      last_word;
  logic                      timeout;
  logic                      round_end;
  logic [PU_COUNT-1:0]       word_shifted;
  logic [PU_COUNT-1:0]       word_mask;
  logic [PU_COUNT-1:0]       vec_next;

  assign syn.in_ready = ready;
  assign accept       = ready & syn.in_valid;
  assign last_word    = syn.in_last | (idx == WORD_IDX_WIDTH'(WORD_COUNT - 1));

  // Shifting in PU_COUNT width drops the padding bits of the final word.
  always_comb begin
    word_shifted = PU_COUNT'(syn.in_data) << (int'(idx) * WORD_WIDTH);
    word_mask    = PU_COUNT'(WORD_ONES) << (int'(idx) * WORD_WIDTH);
    vec_next     = (((idx == '0) ? '0 : is_error_syndromes) & ~word_mask) | word_shifted;
  end

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] wdog;

  // wdog counts WAIT cycles already spent, so the round ends on the TIMEOUT_CYCLES-th one.
  assign timeout = (state == WAIT) && (wdog == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
    end else if (state != WAIT) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign round_end = result_valid | deadlock | timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= LOAD;
      idx                <= '0;
      ready              <= 1'b1;
      is_error_syndromes <= '0;
      new_round_start    <= 1'b0;
      busy               <= 1'b0;
      round_done         <= 1'b0;
      round_error        <= 1'b0;
      round_count        <= '0;
    end else begin
      new_round_start <= 1'b0;
      round_done      <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            is_error_syndromes <= vec_next;
            if (idx == '0) begin
              round_error <= 1'b0;
            end
            if (last_word) begin
              state           <= START;
              idx             <= '0;
              ready           <= 1'b0;
              new_round_start <= 1'b1;
              busy            <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (round_end) begin
            state       <= LOAD;
            ready       <= 1'b1;
            busy        <= 1'b0;
            round_done  <= 1'b1;
            round_count <= round_count + 1'b1;
            round_error <= round_error | deadlock | timeout;
          end
        end
        default: begin
          state <= LOAD;
          idx   <= '0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/leaf_syndrome_loader.md
Name: leaf_syndrome_loader

Overview:
- Upstream feeder for one leaf decoder (grid + stage controller + final arbitration).
- Accepts the per-round error-syndrome bitmap as a stream of fixed-width words over a valid/ready handshake and assembles the PU_COUNT-bit is_error_syndromes vector.
- Fires the one-cycle new_round_start pulse and holds the vector stable until the leaf reports result_valid or deadlock, then re-opens for the next round.
- Counts completed rounds and flags deadlocked rounds.

Parameters:
- CODE_DISTANCE_X, 3, X code distance (must match the leaf)
- CODE_DISTANCE_Z, 2, Z code distance (must match the leaf)
- WORD_WIDTH, 8, input word width in bits
- ROUND_COUNTER_WIDTH, 16, width of the completed-round counter
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with LOADER_TIMEOUT_EN
- Derived: MEASUREMENT_ROUNDS = max(X,Z); PU_COUNT = X*Z*MEASUREMENT_ROUNDS; WORD_COUNT = ceil(PU_COUNT/WORD_WIDTH); WORD_IDX_WIDTH = $clog2(WORD_COUNT+1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- in_data  input  WORD_WIDTH  syndrome word; bit j of word k maps to PU index k*WORD_WIDTH+j
- in_valid  input  1  word valid
- in_last  input  1  final word of the round (qualified by in_valid)
- in_ready  output  1  loader accepts a word this cycle
- is_error_syndromes  output  PU_COUNT  assembled syndrome vector to the leaf
- new_round_start  output  1  one-cycle round-start pulse to the leaf
- result_valid  input  1  leaf finished the round
- deadlock  input  1  leaf stage controller reports deadlock
- busy  output  1  round in flight (START or WAIT)
- round_done  output  1  one-cycle pulse when a round ends
- round_error  output  1  sticky error flag: deadlock, or timeout when the feature is enabled; cleared on next word-0 accept
- round_count  output  ROUND_COUNTER_WIDTH  completed rounds, wraps modulo 2^width

Behaviour:
- Reset (reset low, asynchronous) forces the state below:
  - state LOAD, word index 0
  - is_error_syndromes = 0
  - in_ready = 1; new_round_start = 0; busy = 0; round_done = 0; round_error = 0; round_count = 0
  - Takes effect immediately, including mid-round or mid-load; no pulse is emitted on reset release.
- FSM states: LOAD, START, WAIT.
- LOAD:
  - in_ready = 1. A transfer occurs when in_valid and in_ready are both 1.
  - Word 0 accept: vector := zero-extended word 0 (clears the previous round), round_error := 0.
  - Word k accept: writes bits [k*WORD_WIDTH +: WORD_WIDTH]. Bits at or above PU_COUNT are dropped.
  - Leave to START when the accepted word has in_last = 1 OR word index = WORD_COUNT-1, whichever comes first. An early in_last leaves the remaining bits zero.
  - in_last on word WORD_COUNT-1 is optional. Words arriving after transition are back-pressured (in_ready = 0).
- START:
  - Exactly one cycle; new_round_start = 1, busy = 1, in_ready = 0.
  - Latency: last-word accept in cycle N gives new_round_start in cycle N+1, with the vector already final in N+1.
- WAIT:
  - busy = 1, in_ready = 0, is_error_syndromes held constant.
  - On result_valid or deadlock: round_done = 1 next cycle, round_count += 1, round_error |= deadlock, return to LOAD with word index 0. in_ready = 1 in that same cycle.
  - result_valid and deadlock together count as one round completion, with round_error = 1.
  - result_valid or deadlock asserted during LOAD or START is ignored.
- round_count wraps from all-ones to 0 without any flag.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - 32-bit watchdog counter cleared on entering WAIT, incremented each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no result_valid or deadlock, the round is ended as if deadlock were seen: round_done pulse, round_count += 1, round_error = 1, return to LOAD.
- Undefined: no counter; WAIT persists indefinitely.

Test Plan:
- 18-bit case (X=3, Z=2, W=8):
  - Stimulus: words 0xA5, 0x3C, 0x03 with in_last on the third word.
  - Response: is_error_syndromes = 18'h33CA5; new_round_start high exactly one cycle after the third accept; in_ready = 0 until result_valid.
- Early last:
  - Stimulus: single word 0xFF with in_last.
  - Response: vector = 18'h000FF, START next cycle.
  - Next round: word 0 = 0x01 clears the vector to 18'h00001.
- Back-pressure:
  - Stimulus: hold in_valid high through WAIT.
  - Response: no word accepted; result_valid in cycle M gives round_done and in_ready = 1 in M+1, round_count = 1.
- Deadlock:
  - Stimulus: deadlock = 1 in WAIT.
  - Response: round_done pulse, round_error = 1, round_count incremented; round_error cleared on next word-0 accept.
- Reset mid-load:
  - Stimulus: reset low after word 1.
  - Response: vector = 0, index 0, round_count = 0, no new_round_start; a fresh 3-word load works normally.
- Timeout (LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16):
  - Stimulus: no result_valid.
  - Response: round_done exactly 16 WAIT cycles after entry, round_error = 1.
  - Undefined build: busy stays 1 for 100 cycles.
